// File: rtl/down_counter16_if.sv
// Control/status bundle for the loadable down-counter.
// master drives load/start/pause; slave returns count and flags.
interface down_counter16_if #(
   parameter int WIDTH = 16
);
   logic             load;
   logic [WIDTH-1:0] in;
   logic             start;
   logic             pause;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             zero;

   modport master (
      output load,
      output in,
      output start,
      output pause,
      input  out,
      input  busy,
      input  done,
      input  zero
   );

   modport slave (
      input  load,
      input  in,
      input  start,
      input  pause,
      output out,
      output busy,
      output done,
      output zero
   );
endinterface

// File: rtl/down_counter16.sv
// Loadable down-counter/timer with pause, optional auto-reload
// and a one-cycle done pulse on expiry.
module down_counter16 #(
   parameter int WIDTH       = 16,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   down_counter16_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (bus.load) begin
         cnt_d    = bus.in;
         reload_d = bus.in;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // starting from zero expires at once rather than wrapping
               if (!bus.pause && bus.start) begin
                  if (cnt_q != '0) state_d = RUN;
                  else             done_d  = 1'b1;
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_d = PAUSE;
               end else if (cnt_q > WIDTH'(1)) begin
                  cnt_d = cnt_q - WIDTH'(1);
               end else begin
                  done_d = 1'b1;
                  if (AUTO_RELOAD && reload_q > WIDTH'(1)) begin
                     cnt_d = reload_q;
                  end else begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end
            end
            PAUSE: begin
               if (!bus.pause && bus.start) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == RUN) || (state_d == PAUSE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.out  = cnt_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.zero = (cnt_q == '0);

endmodule

// File: tb/tb_down_counter16.sv
// Bench for down_counter16: one plain and one auto-reload instance,
// vector table plus scoreboard queue, and async-reset checks.
module tb_down_counter16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   down_counter16_if #(.WIDTH(16)) if0 ();
   down_counter16_if #(.WIDTH(16)) if1 ();

   down_counter16 #(.WIDTH(16), .AUTO_RELOAD(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   down_counter16 #(.WIDTH(16), .AUTO_RELOAD(1'b1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   typedef struct {
      bit          ar;
      bit          ld;
      logic [15:0] din;
      bit          st;
      bit          ps;
      logic [15:0] eo;
      bit          eb;
      bit          ed;
      bit          ez;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   step  = 0;

   function automatic vec_t mk(bit ar, bit ld, logic [15:0] din,
                               bit st, bit ps, logic [15:0] eo,
                               bit eb, bit ed);
      vec_t v;
      v.ar  = ar;
      v.ld  = ld;
      v.din = din;
      v.st  = st;
      v.ps  = ps;
      v.eo  = eo;
      v.eb  = eb;
      v.ed  = ed;
      v.ez  = (eo == 16'h0000);
      return v;
   endfunction

   task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL step %0d %s: got %h, want %h", step, nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      if0.load = 1'b0; if0.in = 16'h0; if0.start = 1'b0; if0.pause = 1'b0;
      if1.load = 1'b0; if1.in = 16'h0; if1.start = 1'b0; if1.pause = 1'b0;
   endtask

   task automatic score();
      vec_t e;
      if (exp_q.size() == 0) begin
         cmp("scoreboard_empty", 16'd0, 16'd1);
         return;
      end
      e = exp_q.pop_front();
      if (e.ar) begin
         cmp("ar.out",  if1.out,          e.eo);
         cmp("ar.busy", {15'b0, if1.busy}, {15'b0, e.eb});
         cmp("ar.done", {15'b0, if1.done}, {15'b0, e.ed});
         cmp("ar.zero", {15'b0, if1.zero}, {15'b0, e.ez});
      end else begin
         cmp("out",  if0.out,          e.eo);
         cmp("busy", {15'b0, if0.busy}, {15'b0, e.eb});
         cmp("done", {15'b0, if0.done}, {15'b0, e.ed});
         cmp("zero", {15'b0, if0.zero}, {15'b0, e.ez});
      end
   endtask

   task automatic apply(vec_t v);
      idle_inputs();
      if (v.ar) begin
         if1.load = v.ld; if1.in = v.din; if1.start = v.st; if1.pause = v.ps;
      end else begin
         if0.load = v.ld; if0.in = v.din; if0.start = v.st; if0.pause = v.ps;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      step++;
      score();
   endtask

   task automatic chk_reset(string tag);
      cmp({tag, ".out"},  if0.out,           16'h0000);
      cmp({tag, ".busy"}, {15'b0, if0.busy}, 16'h0000);
      cmp({tag, ".done"}, {15'b0, if0.done}, 16'h0000);
      cmp({tag, ".zero"}, {15'b0, if0.zero}, 16'h0001);
      cmp({tag, ".ar.out"},  if1.out,           16'h0000);
      cmp({tag, ".ar.busy"}, {15'b0, if1.busy}, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // basic count 3 -> 0
      tbl.push_back(mk(0, 1, 16'd3, 0, 0, 16'd3, 0, 0));
      tbl.push_back(mk(0, 0, 16'd0, 1, 0, 16'd3, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd2, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd1, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd0, 0, 1));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd0, 0, 0));
      // start from zero: done only, no wrap
      tbl.push_back(mk(0, 1, 16'd0, 0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(0, 0, 16'd0, 1, 0, 16'd0, 0, 1));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd0, 0, 0));
      // pause / resume
      tbl.push_back(mk(0, 1, 16'd5, 0, 0, 16'd5, 0, 0));
      tbl.push_back(mk(0, 0, 16'd0, 1, 0, 16'd5, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd4, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd3, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 1, 16'd3, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 1, 1, 16'd3, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 1, 16'd3, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 1, 0, 16'd3, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd2, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd1, 1, 0));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd0, 0, 1));
      tbl.push_back(mk(0, 0, 16'd0, 0, 0, 16'd0, 0, 0));
      // auto-reload instance: period 4
      tbl.push_back(mk(1, 1, 16'd4, 0, 0, 16'd4, 0, 0));
      tbl.push_back(mk(1, 0, 16'd0, 1, 0, 16'd4, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd3, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd2, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd1, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd4, 1, 1));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd3, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd2, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd1, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd4, 1, 1));
      tbl.push_back(mk(1, 1, 16'd0, 0, 0, 16'd0, 0, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd0, 0, 0));
      // auto-reload with reload == 1 stops like a plain counter
      tbl.push_back(mk(1, 1, 16'd1, 0, 0, 16'd1, 0, 0));
      tbl.push_back(mk(1, 0, 16'd0, 1, 0, 16'd1, 1, 0));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd0, 0, 1));
      tbl.push_back(mk(1, 0, 16'd0, 0, 0, 16'd0, 0, 0));

      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("rst_rel");

      foreach (tbl[i]) apply(tbl[i]);

      // long count interrupted by a load, then by reset
      apply(mk(0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0));
      apply(mk(0, 0, 16'h0000, 1, 0, 16'hFFFF, 1, 0));
      for (int i = 1; i <= 10; i++)
         apply(mk(0, 0, 16'h0, 0, 0, 16'hFFFF - 16'(i), 1, 0));
      apply(mk(0, 1, 16'h0002, 0, 0, 16'h0002, 0, 0));
      apply(mk(0, 0, 16'h0000, 0, 0, 16'h0002, 0, 0));
      apply(mk(0, 0, 16'h0000, 0, 1, 16'h0002, 0, 0));
      apply(mk(0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0));
      apply(mk(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
